// File: rtl/sm_bcd_sequencer_if.sv
// Conversion request/result bus for sm_bcd_sequencer.
// The master drives start/A. The slave returns ready, valid, sign and bcd.
interface sm_bcd_sequencer_if #(
    parameter int N = 8,
    parameter int D = 3
);
    logic           start;
    logic [N-1:0]   A;
    logic           ready;
    logic           valid;
    logic           sign;
    logic [4*D-1:0] bcd;

    modport master (
        output start, A,
        input  ready, valid, sign, bcd
    );

    modport slave (
        input  start, A,
        output ready, valid, sign, bcd
    );
endinterface

// File: rtl/sm_bcd_sequencer.sv
// Signed binary to sign-magnitude BCD converter.
// The magnitude is converted with a shift-add-3 (double dabble) sequence.
// One conversion takes N SHIFT cycles plus one DONE cycle.
// Optional feature: define SM_BCD_LEADING_BLANK_EN to blank leading zeros.
// When blanking is on, each zero digit above the highest non-zero digit reads
// 4'hF, and digit 0 is always shown.
//
//   state | meaning
//   IDLE  | ready=1, waiting for start, last result held on sign/bcd
//   SHIFT | one double-dabble step per cycle, N cycles in total
//   DONE  | valid=1 for one cycle, then back to IDLE
module sm_bcd_sequencer #(
    parameter int N = 8,
    parameter int D = 3
) (
    input  logic               clk,
    input  logic               rst,
    sm_bcd_sequencer_if.slave  bus
);
    localparam int CW = $clog2(N + 1);

`ifdef SM_BCD_LEADING_BLANK_EN
    localparam logic [4*D-1:0] BCD_RST = {{(D-1){4'hF}}, 4'h0};
`else
    localparam logic [4*D-1:0] BCD_RST = '0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   mag_q, mag_d;
    logic [4*D-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sgn_q, sgn_d;
    logic           out_sign_q, out_sign_d;
    logic [4*D-1:0] bcd_q, bcd_d;

    // Add 3 to every digit that is >= 5 before the shift, so the digit
    // carries correctly into the next nibble.
    function automatic logic [4*D-1:0] add3(input logic [4*D-1:0] a);
        logic [4*D-1:0] r;
        r = a;
        for (int i = 0; i < D; i++) begin
            if (a[4*i +: 4] >= 4'd5)
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

`ifdef SM_BCD_LEADING_BLANK_EN
    // Replace the leading zero digits with 4'hF. Digit 0 is never replaced.
    function automatic logic [4*D-1:0] blank(input logic [4*D-1:0] a);
        logic [4*D-1:0] r;
        logic           seen;
        r    = a;
        seen = 1'b0;
        for (int i = D - 1; i >= 1; i--) begin
            if (a[4*i +: 4] != 4'd0)
                seen = 1'b1;
            else if (!seen)
                r[4*i +: 4] = 4'hF;
        end
        return r;
    endfunction
`endif

    logic [4*D-1:0] acc_adj;
    logic [4*D-1:0] acc_sh;
    logic [N-1:0]   mag_sh;
    logic [N-1:0]   mag_in;

    // Compute the shift datapath, the absolute value of A, and the next state.
    always_comb begin
        state_d    = state_q;
        mag_d      = mag_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sgn_d      = sgn_q;
        out_sign_d = out_sign_q;
        bcd_d      = bcd_q;

        acc_adj          = add3(acc_q);
        {acc_sh, mag_sh} = {acc_adj, mag_q} << 1;
        mag_in           = bus.A[N-1] ? (~bus.A + {{(N-1){1'b0}}, 1'b1}) : bus.A;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sgn_d   = bus.A[N-1];
                    mag_d   = mag_in;
                    acc_d   = '0;
                    cnt_d   = CW'(N);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d = acc_sh;
                mag_d = mag_sh;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    out_sign_d = sgn_q;
`ifdef SM_BCD_LEADING_BLANK_EN
                    bcd_d      = blank(acc_sh);
`else
                    bcd_d      = acc_sh;
`endif
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. rst aborts any conversion in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mag_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            sgn_q      <= 1'b0;
            out_sign_q <= 1'b0;
            bcd_q      <= BCD_RST;
        end else begin
            state_q    <= state_d;
            mag_q      <= mag_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sgn_q      <= sgn_d;
            out_sign_q <= out_sign_d;
            bcd_q      <= bcd_d;
        end
    end

    assign bus.ready = (state_q == IDLE);
    assign bus.valid = (state_q == DONE);
    assign bus.sign  = out_sign_q;
    assign bus.bcd   = bcd_q;
endmodule

// File: tb/tb_sm_bcd_sequencer.sv
// Directed testbench for sm_bcd_sequencer (N=8, D=3).
module tb_sm_bcd_sequencer;
    localparam int N = 8;
    localparam int D = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;

    sm_bcd_sequencer_if #(.N(N), .D(D)) bus ();

    sm_bcd_sequencer #(.N(N), .D(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SM_BCD_LEADING_BLANK_EN
    localparam logic [11:0] E_RST  = 12'hFF0;
    localparam logic [11:0] E_ZERO = 12'hFF0;
    localparam logic [11:0] E_M10  = 12'hF10;
    localparam logic [11:0] E_FIVE = 12'hFF5;
    localparam logic [11:0] E_ONE  = 12'hFF1;
`else
    localparam logic [11:0] E_RST  = 12'h000;
    localparam logic [11:0] E_ZERO = 12'h000;
    localparam logic [11:0] E_M10  = 12'h010;
    localparam logic [11:0] E_FIVE = 12'h005;
    localparam logic [11:0] E_ONE  = 12'h001;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Run one conversion with exact cycle-by-cycle latency checks.
    // Inputs are driven and outputs sampled on negedges.
    // pulse_at > 0 pulses start with A=8'h7F after SHIFT edge pulse_at.
    task automatic conv(input string tag, input logic [7:0] a, input logic exp_sign,
                        input logic [11:0] exp_bcd, input int pulse_at);
        bus.start = 1'b1;
        bus.A     = a;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = ~a;
        chk({tag, "_busy0"}, {31'd0, bus.ready}, 32'd0);
        for (int j = 1; j < N; j++) begin
            @(negedge clk);
            chk({tag, "_novalid"}, {31'd0, bus.valid}, 32'd0);
            chk({tag, "_busy"},    {31'd0, bus.ready}, 32'd0);
            if (pulse_at > 0 && j == pulse_at) begin
                bus.start = 1'b1;
                bus.A     = 8'h7F;
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"},     {31'd0, bus.valid}, 32'd1);
        chk({tag, "_ready_dn"},  {31'd0, bus.ready}, 32'd0);
        chk({tag, "_sign"},      {31'd0, bus.sign},  {31'd0, exp_sign});
        chk({tag, "_bcd"},       {20'd0, bus.bcd},   {20'd0, exp_bcd});
        @(negedge clk);
        chk({tag, "_valid_end"}, {31'd0, bus.valid}, 32'd0);
        chk({tag, "_ready_up"},  {31'd0, bus.ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_hold_sign"}, {31'd0, bus.sign},  {31'd0, exp_sign});
        chk({tag, "_hold_bcd"},  {20'd0, bus.bcd},   {20'd0, exp_bcd});
        chk({tag, "_one_valid"}, {31'd0, bus.valid}, 32'd0);
    endtask

    initial begin
        int pulses;
        int last;
        int ready_cnt;

        bus.start = 1'b0;
        bus.A     = 8'h00;

        // Reset behaviour
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", {31'd0, bus.ready}, 32'd1);
        chk("rst_valid", {31'd0, bus.valid}, 32'd0);
        chk("rst_sign",  {31'd0, bus.sign},  32'd0);
        chk("rst_bcd",   {20'd0, bus.bcd},   {20'd0, E_RST});
        @(negedge clk);

        // Directed conversions
        conv("m123", 8'h85, 1'b1, 12'h123, 0);
        conv("m128", 8'h80, 1'b1, 12'h128, 0);
        conv("p127", 8'h7F, 1'b0, 12'h127, 0);
        conv("zero", 8'h00, 1'b0, E_ZERO,  0);
        conv("m10",  8'hF6, 1'b1, E_M10,   0);
        conv("p5mid", 8'h05, 1'b0, E_FIVE, 3);

        // Abort with rst during the 4th SHIFT cycle
        bus.start = 1'b1;
        bus.A     = 8'h85;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        chk("abort_ready", {31'd0, bus.ready}, 32'd1);
        chk("abort_valid", {31'd0, bus.valid}, 32'd0);
        chk("abort_sign",  {31'd0, bus.sign},  32'd0);
        chk("abort_bcd",   {20'd0, bus.bcd},   {20'd0, E_RST});
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.valid) pulses++;
        end
        chk("abort_no_valid", pulses, 0);
        chk("abort_bcd_hold", {20'd0, bus.bcd}, {20'd0, E_RST});

        // Back-to-back conversions with start held high
        bus.start = 1'b1;
        bus.A     = 8'h01;
        pulses    = 0;
        last      = -1;
        ready_cnt = 0;
        @(posedge clk);
        for (int i = 1; i <= 45; i++) begin
            @(negedge clk);
            if (bus.valid) begin
                pulses++;
                chk("b2b_bcd",  {20'd0, bus.bcd}, {20'd0, E_ONE});
                chk("b2b_sign", {31'd0, bus.sign}, 32'd0);
                if (last < 0) chk("b2b_first", i, 9);
                else begin
                    chk("b2b_period", i - last, 10);
                    chk("b2b_ready1", ready_cnt, 1);
                end
                last      = i;
                ready_cnt = 0;
            end else if (bus.ready) begin
                ready_cnt++;
            end
        end
        chk("b2b_pulses", pulses, 4);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
